// File: rtl/vga_vram_arbiter_pkg.sv
// Shared types and defaults for the VGA video-RAM arbiter.
package vga_vram_arbiter_pkg;

  localparam int unsigned VramAddrWDefault  = 15;
  localparam int unsigned CpuMaxWaitDefault = 4;
  localparam int unsigned DataW             = 16;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbAccess,
    ArbComplete
  } arb_state_t;

  typedef enum logic [1:0] {
    OwnNone,
    OwnCpu,
    OwnFb
  } arb_owner_t;

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// CPU data-bus slave window plus display fetch channel seen by the VRAM arbiter.
interface vga_vram_arbiter_if #(
  parameter int unsigned AddrW = vga_vram_arbiter_pkg::VramAddrWDefault
) ();

  logic        cs;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic [1:0]  data_m_bytesel;
  logic        data_m_wr_en;
  logic        data_m_access;
  logic        data_m_ack;

  logic             fb_req;
  logic [AddrW-1:0] fb_addr;
  logic             fb_ack;
  logic [15:0]      fb_data;

  // Requesters: bus decoder / CPU side and the display fetch engine
  modport master (
    output cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
    output fb_req, fb_addr,
    input  data_m_data_out, data_m_ack, fb_ack, fb_data
  );

  // Arbiter side
  modport slave (
    input  cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
    input  fb_req, fb_addr,
    output data_m_data_out, data_m_ack, fb_ack, fb_data
  );

endinterface

// File: rtl/vga_vram_arbiter.sv
// Arbitrates the single-port video RAM between CPU accesses and display fetches.
// Display fetches win ties; a starvation counter forces a CPU grant after CpuMaxWait losses.
module vga_vram_arbiter
  import vga_vram_arbiter_pkg::*;
#(
  parameter int unsigned VramAddrW  = VramAddrWDefault,
  parameter int unsigned CpuMaxWait = CpuMaxWaitDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_vram_arbiter_if.slave    bus,
  output logic                 vram_en,
  output logic                 vram_wr_en,
  output logic [1:0]           vram_bytesel,
  output logic [VramAddrW-1:0] vram_addr,
  output logic [DataW-1:0]     vram_wr_data,
  input  logic [DataW-1:0]     vram_rd_data
);

  localparam int unsigned         StarveW   = $clog2(CpuMaxWait + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(CpuMaxWait);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;

  logic [StarveW-1:0]   starve_q, starve_d;
  logic                 guard_q;
  logic                 cpu_wr_q, cpu_wr_d;
  logic                 en_q, en_d;
  logic                 wr_en_q, wr_en_d;
  logic [1:0]           bytesel_q, bytesel_d;
  logic [VramAddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0]     wdata_q, wdata_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 fb_ack_q, fb_ack_d;
  logic                 cpu_req;

  // Guard masks the cycle after our own ack, while the master is still dropping access
  assign cpu_req = bus.cs & bus.data_m_access & ~guard_q;

  // Next-state, grant decision and registered-output values
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    cpu_wr_d  = cpu_wr_q;
    en_d      = 1'b0;
    wr_en_d   = 1'b0;
    bytesel_d = 2'b00;
    addr_d    = '0;
    wdata_d   = '0;
    cpu_ack_d = 1'b0;
    fb_ack_d  = 1'b0;

    if (!cpu_req) begin
      starve_d = '0;
    end

    unique case (state_q)
      ArbIdle: begin
        if (cpu_req && (!bus.fb_req || starve_q == StarveMax)) begin
          state_d   = ArbAccess;
          owner_d   = OwnCpu;
          starve_d  = '0;
          cpu_wr_d  = bus.data_m_wr_en;
          en_d      = 1'b1;
          wr_en_d   = bus.data_m_wr_en;
          bytesel_d = bus.data_m_bytesel;
          addr_d    = bus.data_m_addr[VramAddrW:1];
          wdata_d   = bus.data_m_wr_en ? bus.data_m_data_in : '0;
        end else if (bus.fb_req) begin
          state_d   = ArbAccess;
          owner_d   = OwnFb;
          cpu_wr_d  = 1'b0;
          en_d      = 1'b1;
          bytesel_d = 2'b11;
          addr_d    = bus.fb_addr;
          if (cpu_req && starve_q != StarveMax) begin
            starve_d = starve_q + StarveW'(1);
          end
        end
      end
      ArbAccess: begin
        // RAM returns data on the next cycle; the ack lines up with it
        state_d   = ArbComplete;
        cpu_ack_d = (owner_q == OwnCpu);
        fb_ack_d  = (owner_q == OwnFb);
      end
      ArbComplete: begin
        state_d = ArbIdle;
        owner_d = OwnNone;
      end
      default: begin
        state_d = ArbIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ArbIdle;
      owner_q   <= OwnNone;
      starve_q  <= '0;
      guard_q   <= 1'b0;
      cpu_wr_q  <= 1'b0;
      en_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      bytesel_q <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_ack_q <= 1'b0;
      fb_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      guard_q   <= cpu_ack_q;
      cpu_wr_q  <= cpu_wr_d;
      en_q      <= en_d;
      wr_en_q   <= wr_en_d;
      bytesel_q <= bytesel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_ack_q <= cpu_ack_d;
      fb_ack_q  <= fb_ack_d;
    end
  end

  assign vram_en      = en_q;
  assign vram_wr_en   = wr_en_q;
  assign vram_bytesel = bytesel_q;
  assign vram_addr    = addr_q;
  assign vram_wr_data = wdata_q;

  // Read data comes straight from the RAM output register, gated by the ack pulse
  assign bus.data_m_ack      = cpu_ack_q;
  assign bus.data_m_data_out = (cpu_ack_q && !cpu_wr_q) ? vram_rd_data : '0;
  assign bus.fb_ack          = fb_ack_q;
  assign bus.fb_data         = fb_ack_q ? vram_rd_data : '0;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: directed scenarios followed by random traffic
// checked against a word-level shadow memory and latency bounds.
module tb_vga_vram_arbiter;
  import vga_vram_arbiter_pkg::*;

  localparam int unsigned AW       = VramAddrWDefault;
  localparam int          MaxWait  = CpuMaxWaitDefault;
  localparam int          CpuBound = 3 * (MaxWait + 2);
  localparam int          FbBound  = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          vram_en;
  logic          vram_wr_en;
  logic [1:0]    vram_bytesel;
  logic [AW-1:0] vram_addr;
  logic [15:0]   vram_wr_data;
  logic [15:0]   vram_rd_data;

  vga_vram_arbiter_if #(.AddrW(AW)) bus ();

  vga_vram_arbiter #(
    .VramAddrW (AW),
    .CpuMaxWait(MaxWait)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .vram_en     (vram_en),
    .vram_wr_en  (vram_wr_en),
    .vram_bytesel(vram_bytesel),
    .vram_addr   (vram_addr),
    .vram_wr_data(vram_wr_data),
    .vram_rd_data(vram_rd_data)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency, byte-lane writes
  logic [15:0] ram    [2**AW];
  logic [15:0] shadow [2**AW];

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] <= 16'h0000;
  end

  always @(posedge clk) begin
    if (vram_en) begin
      if (vram_wr_en && vram_bytesel[0]) ram[vram_addr][7:0] <= vram_wr_data[7:0];
      if (vram_wr_en && vram_bytesel[1]) ram[vram_addr][15:8] <= vram_wr_data[15:8];
      vram_rd_data <= ram[vram_addr];
    end
  end

  int n_cmp      = 0;
  int n_fail     = 0;
  int fb_ack_cnt = 0;
  bit fb_hold    = 1'b0;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] bs);
    merge = old;
    if (bs[1]) merge[15:8] = d[15:8];
    if (bs[0]) merge[7:0] = d[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " vram_en"}, vram_en, 0);
    check({tag, " vram_wr_en"}, vram_wr_en, 0);
    check({tag, " vram_bytesel"}, vram_bytesel, 0);
    check({tag, " vram_addr"}, vram_addr, 0);
    check({tag, " vram_wr_data"}, vram_wr_data, 0);
    check({tag, " data_m_ack"}, bus.data_m_ack, 0);
    check({tag, " data_m_data_out"}, bus.data_m_data_out, 0);
    check({tag, " fb_ack"}, bus.fb_ack, 0);
    check({tag, " fb_data"}, bus.fb_data, 0);
  endtask

  task automatic cpu_drive(input logic wr, input logic [19:0] baddr, input logic [15:0] d,
                           input logic [1:0] bs);
    bus.cs             = 1'b1;
    bus.data_m_access  = 1'b1;
    bus.data_m_wr_en   = wr;
    bus.data_m_addr    = baddr[19:1];
    bus.data_m_data_in = d;
    bus.data_m_bytesel = bs;
  endtask

  task automatic cpu_idle();
    bus.cs            = 1'b0;
    bus.data_m_access = 1'b0;
  endtask

  // Whole CPU transfer with no display traffic: ack, data and latency against the model
  task automatic cpu_xfer(input string tag, input logic wr, input logic [19:0] baddr,
                          input logic [15:0] d, input logic [1:0] bs, input int exp_lat);
    int            lat;
    logic          got;
    logic [AW-1:0] wa;
    wa  = baddr[AW:1];
    cpu_drive(wr, baddr, d, bs);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      got = bus.data_m_ack;
    end
    check({tag, " ack seen"}, got, 1);
    if (got) begin
      check({tag, " data_out"}, bus.data_m_data_out, wr ? 16'h0000 : shadow[wa]);
      check({tag, " latency"}, lat, exp_lat);
      if (wr) shadow[wa] = merge(shadow[wa], d, bs);
    end
    cpu_idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      check({tag, " single ack"}, bus.data_m_ack, 0);
    end
  endtask

  // Handle a display ack: check fetched word, then re-request or drop
  task automatic fb_observe();
    if (bus.fb_ack) begin
      check("fb ack only while requested", bus.fb_req, 1);
      check("fb data", bus.fb_data, shadow[bus.fb_addr]);
      fb_ack_cnt++;
      if (fb_hold) bus.fb_addr = AW'($urandom_range(0, 31));
      else bus.fb_req = 1'b0;
    end
  endtask

  initial begin
    int            lat;
    int            cnt0;
    int            fb_at;
    int            cpu_at;
    int            pulses;
    int            cpu_age;
    int            fb_age;
    logic          got;
    logic          cpu_busy;
    logic          r_wr;
    logic [AW-1:0] r_wa;
    logic [15:0]   r_d;
    logic [1:0]    r_bs;
    logic [3:0]    r_alias;

    for (int i = 0; i < 2**AW; i++) shadow[i] = 16'h0000;
    reset              = 1'b1;
    bus.cs             = 1'b0;
    bus.data_m_addr    = '0;
    bus.data_m_data_in = '0;
    bus.data_m_bytesel = '0;
    bus.data_m_wr_en   = 1'b0;
    bus.data_m_access  = 1'b0;
    bus.fb_req         = 1'b0;
    bus.fb_addr        = '0;
    tick();
    tick();
    check_quiet("reset");
    reset = 1'b0;
    tick();

    // CPU write: strobe one cycle after the request, ack one cycle later
    cpu_drive(1'b1, 20'h00010, 16'hBEEF, 2'b11);
    tick();
    check("t1 vram_en", vram_en, 1);
    check("t1 vram_wr_en", vram_wr_en, 1);
    check("t1 vram_addr", vram_addr, 15'h0008);
    check("t1 vram_wr_data", vram_wr_data, 16'hBEEF);
    check("t1 vram_bytesel", vram_bytesel, 2'b11);
    check("t1 early ack", bus.data_m_ack, 0);
    tick();
    check("t1 ack", bus.data_m_ack, 1);
    check("t1 write data_out", bus.data_m_data_out, 0);
    check("t1 strobe dropped", vram_en, 0);
    shadow[15'h0008] = merge(shadow[15'h0008], 16'hBEEF, 2'b11);
    cpu_idle();
    tick();
    check("t1 single ack", bus.data_m_ack, 0);
    tick();

    // Read back, then an upper-lane write merged with the old low byte
    cpu_xfer("t2 read", 1'b0, 20'h00010, 16'h0000, 2'b11, 2);
    cpu_xfer("t2 hi write", 1'b1, 20'h00010, 16'h12AB, 2'b10, 2);
    cpu_xfer("t2 read merged", 1'b0, 20'h00010, 16'h0000, 2'b11, 2);
    cpu_xfer("t3 prep", 1'b1, 20'h00040, 16'h5A5A, 2'b11, 2);

    // Simultaneous requests with no starvation history: display first
    bus.fb_addr = 15'h0008;
    bus.fb_req  = 1'b1;
    fb_hold     = 1'b0;
    cpu_drive(1'b0, 20'h00040, 16'h0000, 2'b11);
    cnt0   = fb_ack_cnt;
    fb_at  = 0;
    cpu_at = 0;
    for (int c = 1; c <= 20 && cpu_at == 0; c++) begin
      tick();
      fb_observe();
      if (fb_ack_cnt != cnt0 && fb_at == 0) fb_at = c;
      if (bus.data_m_ack) begin
        cpu_at = c;
        check("t3 cpu data", bus.data_m_data_out, shadow[15'h0020]);
        cpu_idle();
      end
    end
    check("t3 fb ack cycle", fb_at, 2);
    check("t3 cpu ack cycle", cpu_at, 5);
    tick();
    tick();

    // Display held busy: CPU gets in after exactly MaxWait display grants, twice running
    fb_hold     = 1'b1;
    bus.fb_addr = 15'h0008;
    bus.fb_req  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cnt0 = fb_ack_cnt;
      lat  = 0;
      while (fb_ack_cnt == cnt0 && lat < 20) begin
        tick();
        fb_observe();
        lat++;
      end
      check("t4 align on fb ack", fb_ack_cnt - cnt0, 1);
      cpu_drive(1'b0, 20'h00040, 16'h0000, 2'b11);
      cnt0 = fb_ack_cnt;
      got  = 1'b0;
      lat  = 0;
      while (!got && lat < 60) begin
        tick();
        fb_observe();
        lat++;
        if (bus.data_m_ack) begin
          got = 1'b1;
          check("t4 cpu data", bus.data_m_data_out, shadow[15'h0020]);
          cpu_idle();
        end
      end
      check("t4 cpu ack seen", got, 1);
      check("t4 display grants before cpu", fb_ack_cnt - cnt0, MaxWait);
    end
    fb_hold = 1'b0;
    lat     = 0;
    while (bus.fb_req && lat < 20) begin
      tick();
      fb_observe();
      lat++;
    end
    check("t4 display drained", bus.fb_req, 0);
    tick();
    tick();

    // Reset during the RAM access of a CPU write: no ack, outputs cleared, retry completes
    cpu_drive(1'b1, 20'h00080, 16'hC0DE, 2'b11);
    tick();
    check("t5 in access", vram_en, 1);
    reset = 1'b1;
    tick();
    check_quiet("t5 after reset");
    reset = 1'b0;
    got   = 1'b0;
    lat   = 0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      got = bus.data_m_ack;
    end
    check("t5 retry ack", got, 1);
    check("t5 retry latency", lat, 2);
    shadow[15'h0040] = merge(shadow[15'h0040], 16'hC0DE, 2'b11);
    cpu_idle();
    tick();
    tick();
    cpu_xfer("t5 read back", 1'b0, 20'h00080, 16'h0000, 2'b11, 2);

    // Access held one cycle past ack must not start a second transfer
    cpu_drive(1'b1, 20'h000A0, 16'h7777, 2'b01);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      got = bus.data_m_ack;
    end
    check("t6 ack", got, 1);
    shadow[15'h0050] = merge(shadow[15'h0050], 16'h7777, 2'b01);
    tick();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (vram_en || bus.data_m_ack) pulses++;
      if (i == 0) cpu_idle();
      tick();
    end
    check("t6 guard blocks regrant", pulses, 0);

    // Access without chip select belongs to another slave
    bus.cs            = 1'b0;
    bus.data_m_access = 1'b1;
    bus.data_m_wr_en  = 1'b1;
    pulses            = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vram_en || bus.data_m_ack) pulses++;
    end
    check("t6 cs low ignored", pulses, 0);
    cpu_idle();
    tick();
    cpu_xfer("t6 low lane read", 1'b0, 20'h000A0, 16'h0000, 2'b11, 2);

    // Random mixed traffic against the shadow memory and wait bounds
    cpu_busy = 1'b0;
    cpu_age  = 0;
    fb_age   = 0;
    r_wr     = 1'b0;
    r_wa     = '0;
    r_d      = '0;
    r_bs     = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!cpu_busy && $urandom_range(0, 2) == 0) begin
        r_wr    = 1'($urandom_range(0, 1));
        r_wa    = AW'($urandom_range(0, 31));
        r_alias = 4'($urandom);
        r_d     = 16'($urandom);
        r_bs    = 2'($urandom);
        cpu_drive(r_wr, {r_alias, r_wa, 1'b0}, r_d, r_bs);
        cpu_busy = 1'b1;
        cpu_age  = 0;
      end
      if (!bus.fb_req && $urandom_range(0, 2) == 0) begin
        bus.fb_addr = AW'($urandom_range(0, 31));
        bus.fb_req  = 1'b1;
        fb_age      = 0;
      end
      tick();
      if (bus.fb_req) fb_age++;
      if (cpu_busy) cpu_age++;
      cnt0 = fb_ack_cnt;
      fb_observe();
      if (fb_ack_cnt != cnt0) check("rnd fb wait within bound", fb_age <= FbBound, 1);
      else if (bus.fb_req && fb_age > FbBound) begin
        check("rnd fb timeout", fb_age, FbBound);
        bus.fb_req = 1'b0;
      end
      if (bus.data_m_ack) begin
        check("rnd cpu ack while pending", cpu_busy, 1);
        check("rnd cpu data", bus.data_m_data_out, r_wr ? 16'h0000 : shadow[r_wa]);
        check("rnd cpu wait within bound", cpu_age <= CpuBound, 1);
        if (r_wr) shadow[r_wa] = merge(shadow[r_wa], r_d, r_bs);
        cpu_idle();
        cpu_busy = 1'b0;
      end else if (cpu_busy && cpu_age > CpuBound) begin
        check("rnd cpu timeout", cpu_age, CpuBound);
        cpu_idle();
        cpu_busy = 1'b0;
      end
    end
    cpu_idle();
    bus.fb_req = 1'b0;
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
